// File: rtl/ps2_dma_pkg.sv
// Shared types and constants for the PS/2 keystroke-buffer to memory controller.
package ps2_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int OVERRUN_MAX = 255;
    localparam int WORD_W      = 32;

endpackage

// File: rtl/ps2_dma_addr_gen.sv
// Circular write-address register over BASE_ADDR .. BASE_ADDR+DEPTH-1.
module ps2_dma_addr_gen #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

    assign at_last = (addr == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= FIRST_ADDR;
        end else if (advance) begin
            addr <= at_last ? FIRST_ADDR : addr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_dma_ctrl.sv
// PS/2 buffer word mover: latch, clear buffer, write to circular memory region.
// Optional dropped-word counter enabled by defining PS2DMA_OVERRUN_EN.
//
// state | meaning
// IDLE  | waiting for a word_valid rising edge while enabled
// LATCH | one cycle: buf_clear pulsed, word captured, timeout loaded
// WRITE | mem_req held until ack or timeout
module ps2_dma_ctrl
    import ps2_dma_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    output logic              buf_clear,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              wrap_irq,
    output logic              err,
`ifdef PS2DMA_OVERRUN_EN
    output logic [7:0]        overrun_cnt,
`endif
    output logic [15:0]       wr_count
);

    // Counter is loaded with TIMEOUT_CYC-1 so terminal count 0 lands on the last req cycle.
    localparam int              TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic             wv_q;
    logic             start;
    logic             ack;
    logic             at_last;
    logic [TMR_W-1:0] tmr;

    assign start = word_valid & ~wv_q;
    assign ack   = mem_req & mem_ack;

    ps2_dma_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .advance (ack),
        .addr    (mem_addr),
        .at_last (at_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wv_q      <= 1'b0;
            buf_clear <= 1'b0;
            mem_req   <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            wrap_irq  <= 1'b0;
            err       <= 1'b0;
            wr_count  <= '0;
            tmr       <= '0;
        end else begin
            wv_q      <= word_valid;
            buf_clear <= 1'b0;
            wrap_irq  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && enable) begin
                        state     <= LATCH;
                        buf_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LATCH: begin
                    state     <= WRITE;
                    mem_wdata <= word_in;
                    mem_req   <= 1'b1;
                    tmr       <= TMR_LOAD;
                end
                WRITE: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        wr_count <= wr_count + 16'd1;
                        wrap_irq <= at_last;
                    end else if (tmr == '0) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PS2DMA_OVERRUN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (start && (state != IDLE) && (overrun_cnt != 8'(OVERRUN_MAX))) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_dma_ctrl.sv
// Directed bench for ps2_dma_ctrl with a 4-word region and an 8-cycle write timeout.
module tb_ps2_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        word_valid;
    logic [31:0] word_in;
    logic        buf_clear;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        wrap_irq;
    logic        err;
    logic [15:0] wr_count;
`ifdef PS2DMA_OVERRUN_EN
    logic [7:0]  overrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int clr_cnt = 0;
    int wrap_cnt = 0;

    ps2_dma_ctrl #(
        .ADDR_W      (10),
        .BASE_ADDR   (0),
        .DEPTH       (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .word_valid  (word_valid),
        .word_in     (word_in),
        .buf_clear   (buf_clear),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .wrap_irq    (wrap_irq),
        .err         (err),
`ifdef PS2DMA_OVERRUN_EN
        .overrun_cnt (overrun_cnt),
`endif
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            if (buf_clear) clr_cnt++;
            if (wrap_irq)  wrap_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete word: rising edge, LATCH, WRITE for dly+1 cycles, ack, release.
    task automatic do_word(input logic [31:0] data, input int dly,
                           input logic [31:0] exp_addr, input logic exp_wrap);
        word_in    = data;
        word_valid = 1'b1;
        tick();
        chk("latch_clr", buf_clear, 1);
        chk("latch_busy", busy, 1);
        chk("latch_noreq", mem_req, 0);
        tick();
        chk("req_up", mem_req, 1);
        chk("wdata", mem_wdata, data);
        chk("clr_pulse", buf_clear, 0);
        chk("req_addr", mem_addr, exp_addr);
        repeat (dly) tick();
        chk("req_held", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("req_down", mem_req, 0);
        chk("wrap_irq", wrap_irq, exp_wrap);
        word_valid = 1'b0;
        tick();
        chk("wrap_pulse", wrap_irq, 0);
    endtask

    initial begin
        int n;
        int c0;
        reset      = 1'b1;
        enable     = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        mem_ack    = 1'b0;
        repeat (3) tick();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wrcnt", wr_count, 0);
        chk("rst_clr", buf_clear, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        tick();
        enable = 1'b1;

        // single word, word_valid high for 5 cycles
        do_word(32'h1C32231B, 2, 0, 0);
        chk("single_wrcnt", wr_count, 1);
        chk("single_clrs", clr_cnt, 1);
        chk("single_addr", mem_addr, 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_wrcnt", wr_count, 0);
        chk("rst2_addr", mem_addr, 0);

        // wrap across a 4-word region
        for (int i = 0; i < 5; i++) begin
            do_word(32'hA0000000 + i, i % 2, i % 4, (i == 3));
            chk("wrap_wrcnt", wr_count, i + 1);
        end
        chk("wrap_count", wrap_cnt, 1);
        chk("wrap_addr", mem_addr, 1);

        // ack on the final timeout cycle wins over expiry
        do_word(32'h5555AAAA, 7, 1, 0);
        chk("lastcyc_err", err, 0);
        chk("lastcyc_wrcnt", wr_count, 6);
        chk("lastcyc_addr", mem_addr, 2);

        // ack while idle is ignored
        mem_ack = 1'b1;
        repeat (3) tick();
        mem_ack = 1'b0;
        chk("idleack_wrcnt", wr_count, 6);
        chk("idleack_addr", mem_addr, 2);
        chk("idleack_busy", busy, 0);

        // timeout: req held exactly 8 cycles
        word_in    = 32'hDEADBEEF;
        word_valid = 1'b1;
        tick();
        tick();
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick();
        end
        word_valid = 1'b0;
        chk("tmo_cycles", n, 8);
        chk("tmo_err", err, 1);
        chk("tmo_addr", mem_addr, 2);
        chk("tmo_busy", busy, 0);
        chk("tmo_wrcnt", wr_count, 6);
        tick();
        do_word(32'h0BADF00D, 0, 2, 0);
        chk("after_tmo_addr", mem_addr, 3);
        chk("err_sticky", err, 1);

        // enable low while idle: edge discarded, and no late start on re-enable
        c0         = clr_cnt;
        enable     = 1'b0;
        word_valid = 1'b1;
        repeat (3) tick();
        chk("dis_busy", busy, 0);
        chk("dis_clrs", clr_cnt, c0);
        enable = 1'b1;
        repeat (2) tick();
        chk("reen_busy", busy, 0);
        chk("reen_clrs", clr_cnt, c0);
        word_valid = 1'b0;
        tick();

        // enable dropped mid-write still completes
        word_in    = 32'h12345678;
        word_valid = 1'b1;
        tick();
        tick();
        enable     = 1'b0;
        word_valid = 1'b0;
        tick();
        tick();
        chk("endrop_req", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("endrop_done", mem_req, 0);
        chk("endrop_wrcnt", wr_count, 8);
        chk("endrop_addr", mem_addr, 0);
        chk("endrop_wrap", wrap_irq, 1);
        enable = 1'b1;
        tick();

        // second rising edge during WRITE is dropped
        c0         = clr_cnt;
        word_in    = 32'hCAFE0001;
        word_valid = 1'b1;
        tick();
        tick();
        word_valid = 1'b0;
        tick();
        word_valid = 1'b1;
        tick();
        tick();
        chk("ovr_busy", busy, 1);
        chk("ovr_clrs", clr_cnt, c0 + 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ovr_reqdown", mem_req, 0);
        repeat (3) tick();
        chk("ovr_idle", busy, 0);
        chk("ovr_clrs2", clr_cnt, c0 + 1);
        chk("ovr_wrcnt", wr_count, 9);
        chk("ovr_wdata", mem_wdata, 32'hCAFE0001);
        word_valid = 1'b0;
        tick();
`ifdef PS2DMA_OVERRUN_EN
        chk("ovr_cnt1", overrun_cnt, 1);
        for (int i = 0; i < 100; i++) begin
            word_valid = 1'b1;
            tick();
            tick();
            for (int k = 0; k < 3; k++) begin
                word_valid = 1'b0;
                tick();
                word_valid = 1'b1;
                tick();
            end
            mem_ack = 1'b1;
            tick();
            mem_ack    = 1'b0;
            word_valid = 1'b0;
            tick();
        end
        chk("ovr_sat", overrun_cnt, 255);
        chk("ovr_sat_wrcnt", wr_count, 109);
        chk("ovr_sat_err", err, 1);
`endif

        // asynchronous reset in the middle of a write
        c0 = mem_addr;
        chk("pre_rst_addr_nz", (c0 != 0), 1);
        word_in    = 32'h77778888;
        word_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_err", err, 0);
        chk("arst_wrcnt", wr_count, 0);
        chk("arst_busy", busy, 0);
`ifdef PS2DMA_OVERRUN_EN
        chk("arst_ovr", overrun_cnt, 0);
`endif
        word_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
